cmd_seq_pagebuf: RTL and testbench

Two-page command-sequence buffer downstream of the 4-to-1 encoder mux. It captures the merged encoded-command stream (`start`/`enc_cmd`/`enc_wr`/`enc_done`) into one page of block memory. On `enc_done` it hands the finished page, with its word count, to the memory-controller sequencer. The sequencer reads and executes that page while the next sequence fills the other page.

---
 rtl/cmd_seq_pagebuf_if.sv | 38 +++
 rtl/cmd_seq_pagebuf.sv | 161 ++++++++++++++++
 tb/tb_cmd_seq_pagebuf.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_seq_pagebuf_if.sv
// Bus bundle between the encoder mux / sequencer and the two-page command buffer.
// The master side is the upstream encoder plus the sequencer; the slave side is the buffer.
interface cmd_seq_pagebuf_if #(
  parameter int AW = 5
);
  // Fill side (encoder stream)
  logic          start;
  logic [31:0]   enc_cmd;
  logic          enc_wr;
  logic          enc_done;
  logic          wr_free;
  // Read side (sequencer)
  logic          seq_ready;
  logic          seq_page;
  logic [AW:0]   seq_len;
  logic          seq_rd_en;
  logic [AW-1:0] seq_rd_addr;
  logic [31:0]   seq_rd_data;
  logic          seq_done;
  // Error reporting
  logic          err_clr;
  logic          err_nopage;
  logic          err_ovf;

  modport master (
    output start, enc_cmd, enc_wr, enc_done,
    output seq_rd_en, seq_rd_addr, seq_done, err_clr,
    input  wr_free, seq_ready, seq_page, seq_len, seq_rd_data,
    input  err_nopage, err_ovf
  );

  modport slave (
    input  start, enc_cmd, enc_wr, enc_done,
    input  seq_rd_en, seq_rd_addr, seq_done, err_clr,
    output wr_free, seq_ready, seq_page, seq_len, seq_rd_data,
    output err_nopage, err_ovf
  );
endinterface

// File: rtl/cmd_seq_pagebuf.sv
// Two-page command-sequence buffer. One page fills from the encoded-command
// stream while the sequencer reads and executes the other; pages are handed
// over strictly in fill order. All status outputs are registered.
module cmd_seq_pagebuf #(
  parameter int AW = 5
) (
  input logic               clk,
  input logic               rst,
  cmd_seq_pagebuf_if.slave  bus
);
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {PG_FREE, PG_FILL, PG_READY} pg_state_t;
  typedef enum logic       {S_IDLE, S_FILL}             fsm_t;

  // Page bookkeeping
  pg_state_t   pg_q [2];
  pg_state_t   pg_d [2];
  logic [AW:0] len_q [2];
  logic [AW:0] len_d [2];
  fsm_t        st_q, st_d;
  logic        wp_q, wp_d;
  logic        rp_q, rp_d;
  // Fill count doubles as the fill address: words land at 0, 1, 2, ...
  logic [AW:0] cnt_q, cnt_d;
  logic [AW:0] cur_cnt;
  logic        active;

  // Registered outputs
  logic        wr_free_q, wr_free_d;
  logic        seq_ready_q, seq_ready_d;
  logic [AW:0] seq_len_q, seq_len_d;
  logic        nopage_q, nopage_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rd_data_q;

  // Memory write port
  logic            we;
  logic [AW:0]     waddr;
  logic [31:0]     mem [2*DEPTH];

  // Next-state computation for the fill FSM, page states, pointers and flags
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pg_d     = pg_q;
    len_d    = len_q;
    st_d     = st_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    nopage_d = nopage_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    waddr    = '0;
    active   = (st_q == S_FILL);
    cur_cnt  = cnt_q;

    // Clear first so that a same-cycle error re-sets the flag.
    if (bus.err_clr) begin
      nopage_d = 1'b0;
      ovf_d    = 1'b0;
    end

    // Start decisions use page states from before any same-cycle seq_done.
    if (bus.start) begin
      if (st_q == S_FILL) begin
        cur_cnt = '0;
      end else if (pg_q[wp_q] == PG_FREE) begin
        active      = 1'b1;
        cur_cnt     = '0;
        pg_d[wp_q]  = PG_FILL;
        st_d        = S_FILL;
      end else begin
        nopage_d = 1'b1;
      end
    end

    cnt_d = cur_cnt;
    if (active && bus.enc_wr) begin
      if (cur_cnt < FULL) begin
        we    = 1'b1;
        waddr = {wp_q, cur_cnt[AW-1:0]};
        cnt_d = cur_cnt + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Close the page after any same-cycle write has been counted.
    if (active && bus.enc_done) begin
      len_d[wp_q] = cnt_d;
      pg_d[wp_q]  = PG_READY;
      wp_d        = ~wp_q;
      st_d        = S_IDLE;
    end

    if (bus.seq_done && seq_ready_q) begin
      pg_d[rp_q] = PG_FREE;
      rp_d       = ~rp_q;
    end

    wr_free_d   = (pg_d[0] == PG_FREE)  || (pg_d[1] == PG_FREE);
    seq_ready_d = (pg_d[0] == PG_READY) || (pg_d[1] == PG_READY);
    seq_len_d   = len_d[rp_d];
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_q        <= '{PG_FREE, PG_FREE};
      len_q       <= '{default: '0};
      st_q        <= S_IDLE;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      cnt_q       <= '0;
      wr_free_q   <= 1'b1;
      seq_ready_q <= 1'b0;
      seq_len_q   <= '0;
      nopage_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      pg_q        <= pg_d;
      len_q       <= len_d;
      st_q        <= st_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      wr_free_q   <= wr_free_d;
      seq_ready_q <= seq_ready_d;
      seq_len_q   <= seq_len_d;
      nopage_q    <= nopage_d;
      ovf_q       <= ovf_d;
    end
  end

  // Page memory write port
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset so it maps onto block RAM.
    if (we) begin
      mem[waddr] <= bus.enc_cmd;
    end
  end

  // Registered read port; holds its value while no read is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (bus.seq_rd_en) begin
      rd_data_q <= mem[{rp_q, bus.seq_rd_addr}];
    end
  end

  assign bus.wr_free     = wr_free_q;
  assign bus.seq_ready   = seq_ready_q;
  assign bus.seq_page    = rp_q;
  assign bus.seq_len     = seq_len_q;
  assign bus.seq_rd_data = rd_data_q;
  assign bus.err_nopage  = nopage_q;
  assign bus.err_ovf     = ovf_q;
endmodule

// File: tb/tb_cmd_seq_pagebuf.sv
// Self-checking bench for cmd_seq_pagebuf: directed scenarios with literal
// expectations, then random traffic, all compared every cycle against a
// counting/array model of the page buffer.
module tb_cmd_seq_pagebuf;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_seq_pagebuf_if #(.AW(AW)) bus();
  cmd_seq_pagebuf #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts of ready pages, fills and consumptions
  bit          m_filling;
  int          m_cnt;
  int          m_ready;
  int          m_filled;
  int          m_consumed;
  int          m_len [2];
  bit          m_nopage;
  bit          m_ovf;
  logic [31:0] m_mem [2*DEPTH];
  bit          m_known [2*DEPTH];
  logic [31:0] m_rd;
  bit          m_rd_known;

  task automatic model_reset();
    m_filling  = 1'b0;
    m_cnt      = 0;
    m_ready    = 0;
    m_filled   = 0;
    m_consumed = 0;
    m_len[0]   = 0;
    m_len[1]   = 0;
    m_nopage   = 1'b0;
    m_ovf      = 1'b0;
    m_rd       = '0;
    m_rd_known = 1'b1;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    int ready_before;
    int wp;
    int rp;
    int a;
    ready_before = m_ready;
    wp = m_filled % 2;
    rp = m_consumed % 2;
    if (bus.seq_rd_en) begin
      a = rp * DEPTH + int'(bus.seq_rd_addr);
      m_rd_known = m_known[a];
      m_rd = m_mem[a];
    end
    if (bus.err_clr) begin
      m_nopage = 1'b0;
      m_ovf = 1'b0;
    end
    if (bus.start) begin
      if (m_filling) m_cnt = 0;
      else if (ready_before < 2) begin
        m_filling = 1'b1;
        m_cnt = 0;
      end else m_nopage = 1'b1;
    end
    if (m_filling && bus.enc_wr) begin
      if (m_cnt < DEPTH) begin
        a = wp * DEPTH + m_cnt;
        m_mem[a] = bus.enc_cmd;
        m_known[a] = 1'b1;
        m_cnt++;
      end else m_ovf = 1'b1;
    end
    if (m_filling && bus.enc_done) begin
      m_len[wp] = m_cnt;
      m_ready++;
      m_filled++;
      m_filling = 1'b0;
    end
    if (bus.seq_done && ready_before > 0) begin
      m_ready--;
      m_consumed++;
    end
  endtask

  task automatic compare_all();
    int free_pages;
    free_pages = 2 - m_ready - (m_filling ? 1 : 0);
    check("wr_free",    32'(bus.wr_free),    32'(free_pages > 0));
    check("seq_ready",  32'(bus.seq_ready),  32'(m_ready > 0));
    check("seq_page",   32'(bus.seq_page),   32'(m_consumed % 2));
    check("seq_len",    32'(bus.seq_len),    32'(m_len[m_consumed % 2]));
    check("err_nopage", 32'(bus.err_nopage), 32'(m_nopage));
    check("err_ovf",    32'(bus.err_ovf),    32'(m_ovf));
    if (m_rd_known) check("seq_rd_data", bus.seq_rd_data, m_rd);
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.enc_cmd = '0; bus.enc_wr = 1'b0; bus.enc_done = 1'b0;
    bus.seq_done = 1'b0; bus.seq_rd_en = 1'b0; bus.seq_rd_addr = '0; bus.err_clr = 1'b0;
  endtask

  // Apply one cycle of inputs, step the model, then compare after the edge
  task automatic drive(input bit s, input bit wr, input logic [31:0] cmd, input bit done,
                       input bit sd = 1'b0, input bit rden = 1'b0,
                       input logic [AW-1:0] ra = '0, input bit clr = 1'b0);
    bus.start = s; bus.enc_wr = wr; bus.enc_cmd = cmd; bus.enc_done = done;
    bus.seq_done = sd; bus.seq_rd_en = rden; bus.seq_rd_addr = ra; bus.err_clr = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    idle_inputs();
  endtask

  task automatic rd(input logic [AW-1:0] ra);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, ra);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_wr_free",    32'(bus.wr_free),    32'd1);
    check("rst_seq_ready",  32'(bus.seq_ready),  32'd0);
    check("rst_seq_page",   32'(bus.seq_page),   32'd0);
    check("rst_seq_len",    32'(bus.seq_len),    32'd0);
    check("rst_rd_data",    bus.seq_rd_data,     32'd0);
    check("rst_err_nopage", 32'(bus.err_nopage), 32'd0);
    check("rst_err_ovf",    32'(bus.err_ovf),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    do_reset();

    // Basic fill and read
    drive(1, 1, 32'hA0, 0);
    drive(0, 1, 32'hA1, 0);
    drive(0, 1, 32'hA2, 0);
    drive(0, 0, 0, 1);
    check("basic_ready", 32'(bus.seq_ready), 32'd1);
    check("basic_page",  32'(bus.seq_page),  32'd0);
    check("basic_len",   32'(bus.seq_len),   32'd3);
    for (int i = 0; i < 3; i++) begin
      rd(AW'(i));
      check("basic_rd", bus.seq_rd_data, 32'hA0 + 32'(i));
    end
    drive(0, 0, 0, 0, 1);

    // Double buffering, no-page error beating a same-cycle clear
    do_reset();
    drive(1, 1, 32'hC0, 0);
    drive(0, 1, 32'hC1, 1);
    drive(1, 1, 32'hB0, 0);
    for (int i = 1; i < 4; i++) drive(0, 1, 32'hB0 + 32'(i), 0);
    drive(0, 0, 0, 1);
    check("dbl_wr_free", 32'(bus.wr_free), 32'd0);
    drive(1, 0, 0, 0, 0, 0, '0, 1);
    check("dbl_nopage", 32'(bus.err_nopage), 32'd1);
    drive(0, 1, 32'hEE, 0);
    drive(0, 0, 0, 1);
    check("dbl_len_keep", 32'(bus.seq_len), 32'd2);
    drive(0, 0, 0, 0, 1);
    check("dbl_page", 32'(bus.seq_page), 32'd1);
    check("dbl_len",  32'(bus.seq_len),  32'd4);
    check("dbl_free", 32'(bus.wr_free),  32'd1);
    rd(2'd3);
    check("dbl_rd", bus.seq_rd_data, 32'hB3);

    // Overflow
    do_reset();
    drive(1, 1, 32'hD0, 0);
    for (int i = 1; i < 5; i++) drive(0, 1, 32'hD0 + 32'(i), 0);
    drive(0, 0, 0, 1);
    check("ovf_len",  32'(bus.seq_len), 32'd4);
    check("ovf_flag", 32'(bus.err_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(AW'(i));
      check("ovf_rd", bus.seq_rd_data, 32'hD0 + 32'(i));
    end
    drive(0, 0, 0, 0, 0, 0, '0, 1);
    check("ovf_clr", 32'(bus.err_ovf), 32'd0);

    // Corner coincidences
    do_reset();
    drive(1, 1, 32'h55, 0);
    drive(0, 0, 0, 1);
    rd(2'd0);
    check("corner_start_wr", bus.seq_rd_data, 32'h55);
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 32'h10, 0);
    drive(0, 1, 32'h11, 1);
    check("corner_wr_done_len", 32'(bus.seq_len), 32'd2);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    check("zero_ready", 32'(bus.seq_ready), 32'd1);
    check("zero_len",   32'(bus.seq_len),   32'd0);

    // Restart mid-fill
    do_reset();
    drive(1, 1, 32'h01, 0);
    drive(0, 1, 32'h02, 0);
    drive(0, 1, 32'h03, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 32'h77, 0);
    drive(0, 0, 0, 1);
    check("restart_len", 32'(bus.seq_len), 32'd1);
    rd(2'd0);
    check("restart_rd", bus.seq_rd_data, 32'h77);

    // Reset during fill: partial page discarded, next fill lands on page 0
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 32'h90, 0);
    drive(0, 1, 32'h91, 0);
    do_reset();
    drive(1, 1, 32'h92, 0);
    drive(0, 0, 0, 1);
    check("post_rst_page", 32'(bus.seq_page), 32'd0);
    rd(2'd0);
    check("post_rst_rd", bus.seq_rd_data, 32'h92);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 19) == 0, 1'($urandom), $urandom,
            $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
            1'($urandom), AW'($urandom), $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
